// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: 3-sample majority per bit, optional parity, 1-2 stop bits, registered word + flags.
// Latency: valid rises 1 clk after the ce cycle holding the last stop decision (plus 2 clk rxd synchroniser).
// Backpressure: valid/data held until ready; a word completing while one is still held is dropped and overrun pulses.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 ce,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [2:0]           status
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam int H  = OVERSAMPLE / 2;
    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          STP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_START  = 3'b001,
        S_DATA   = 3'b010,
        S_PARITY = 3'b011,
        S_STOP   = 3'b100
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [IW-1:0]        bit_idx, idx_nxt;
    logic                 stop_idx, stp_nxt;
    logic [DATA_BITS-1:0] shreg, sh_nxt;
    logic                 perr_acc, pe_nxt;
    logic                 ferr_acc, fe_nxt;
    logic                 done;
    logic                 rx_meta, rx_s;
    logic                 s0, s1;
    logic                 maj, dec, last, par_exp;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    // The third vote is the live synchronised sample on the decision tick.
    assign maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign dec     = (cnt == CNT_DEC);
    assign last    = (cnt == CNT_LAST);
    assign par_exp = (PARITY == 2) ? ~(^shreg) : ^shreg;
    assign status  = state;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else if (ce) begin
            if (cnt == CNT_S0) s0 <= rx_s;
            if (cnt == CNT_S1) s1 <= rx_s;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = bit_idx;
        stp_nxt   = stop_idx;
        sh_nxt    = shreg;
        pe_nxt    = perr_acc;
        fe_nxt    = ferr_acc;
        done      = 1'b0;
        if (ce) begin
            cnt_nxt = last ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    cnt_nxt = '0;
                    idx_nxt = '0;
                    stp_nxt = 1'b0;
                    pe_nxt  = 1'b0;
                    fe_nxt  = 1'b0;
                    if (!rx_s) state_nxt = S_START;
                end
                S_START: begin
                    if (dec && maj) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else if (last) begin
                        state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    if (dec) sh_nxt = {maj, shreg[DATA_BITS-1:1]};
                    if (last) begin
                        if (bit_idx == IDX_LAST) begin
                            idx_nxt   = '0;
                            state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_nxt = bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (dec) pe_nxt = (maj != par_exp);
                    if (last) state_nxt = S_STOP;
                end
                S_STOP: begin
                    if (dec) begin
                        if (!maj) fe_nxt = 1'b1;
                        // Leave on the last decision so a start edge right after the stop bit is caught.
                        if (stop_idx == STP_LAST) begin
                            done      = 1'b1;
                            state_nxt = S_IDLE;
                            cnt_nxt   = '0;
                        end
                    end else if (last) begin
                        stp_nxt = stop_idx + 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= idx_nxt;
            stop_idx <= stp_nxt;
            shreg    <= sh_nxt;
            perr_acc <= pe_nxt;
            ferr_acc <= fe_nxt;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= done && valid && !ready;
            if (done && (!valid || ready)) begin
                data       <= shreg;
                parity_err <= perr_acc;
                frame_err  <= fe_nxt;
                valid      <= 1'b1;
            end else if (!done && valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1 instance and an 8E2 instance, a frame-level expectation model and directed vectors.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       clr_n, ce, rxd0, rxd1, ready0, ready1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, perr0, perr1, ferr0, ferr1, ovr0, ovr1;
    logic [2:0] status0, status1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Frame requests posted by the stimulus, consumed by the model at the predicted completion cycle.
    int         req_seq [2] = '{0, 0};
    int         done_seq[2] = '{0, 0};
    int         req_due [2];
    logic [7:0] req_data[2];
    logic       req_perr[2];
    logic       req_ferr[2];

    logic       m_valid[2];
    logic [7:0] m_data [2];
    logic       m_perr [2];
    logic       m_ferr [2];
    logic       m_ovr  [2];
    logic       m_rdy;

    int   rise0 = 0;
    logic pv0   = 1'b0;
    int   novr0 = 0;
    int   k, n0;

    always #5 clk = ~clk;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .clr_n(clr_n), .ce(ce), .rxd(rxd0), .data(data0), .valid(valid0),
        .ready(ready0), .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0), .status(status0)
    );

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .clr_n(clr_n), .ce(ce), .rxd(rxd1), .data(data1), .valid(valid1),
        .ready(ready1), .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1), .status(status1)
    );

    // Word-level model: a completed frame either lands in the output slot or is dropped with an overrun pulse.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            m_rdy = (i == 0) ? ready0 : ready1;
            if (!clr_n) begin
                m_valid[i]  = 1'b0;
                m_data[i]   = 8'h00;
                m_perr[i]   = 1'b0;
                m_ferr[i]   = 1'b0;
                m_ovr[i]    = 1'b0;
                done_seq[i] = req_seq[i];
            end else begin
                m_ovr[i] = 1'b0;
                if (done_seq[i] != req_seq[i] && cyc == req_due[i]) begin
                    done_seq[i] = req_seq[i];
                    if (!m_valid[i] || m_rdy) begin
                        m_valid[i] = 1'b1;
                        m_data[i]  = req_data[i];
                        m_perr[i]  = req_perr[i];
                        m_ferr[i]  = req_ferr[i];
                    end else begin
                        m_ovr[i] = 1'b1;
                    end
                end else if (m_valid[i] && m_rdy) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_one(input int i, input logic v, input logic [7:0] d,
                           input logic pe, input logic fe, input logic ov);
        chk($sformatf("valid%0d", i), 32'(v), 32'(m_valid[i]));
        if (m_valid[i]) begin
            chk($sformatf("data%0d", i), 32'(d), 32'(m_data[i]));
            chk($sformatf("parity_err%0d", i), 32'(pe), 32'(m_perr[i]));
            chk($sformatf("frame_err%0d", i), 32'(fe), 32'(m_ferr[i]));
        end
        chk($sformatf("overrun%0d", i), 32'(ov), 32'(m_ovr[i]));
    endtask

    // Frame on the wire: start, 8 data LSB-first, even parity (dut1 only), stop bit(s).
    // Completion cycle = drive cycle + 3 (sync + idle detect) + 16 per earlier bit + (H+1) + 1.
    task automatic send(input int i, input logic [7:0] d, input logic par_flip,
                        input logic [1:0] stops, input int gbit, output int start);
        logic bits [12];
        int   nb;
        logic pbit, v;
        bits[0] = 1'b0;
        for (int b = 0; b < 8; b++) bits[1+b] = d[b];
        nb   = 9;
        pbit = (^d) ^ par_flip;
        if (i == 1) begin
            bits[nb] = pbit;
            nb++;
        end
        bits[nb] = stops[0];
        nb++;
        if (i == 1) begin
            bits[nb] = stops[1];
            nb++;
        end
        start = 0;
        for (int b = 0; b < nb; b++) begin
            for (int t = 0; t < 16; t++) begin
                @(negedge clk);
                v = bits[b];
                if (gbit >= 0 && b == gbit + 1 && t == 8) v = 1'b0;
                if (i == 0) rxd0 = v; else rxd1 = v;
                if (b == 0 && t == 0) begin
                    start       = cyc;
                    req_due[i]  = cyc + 13 + 16 * (nb - 1);
                    req_data[i] = d;
                    req_perr[i] = (i == 1) && (pbit != ^d);
                    req_ferr[i] = (i == 0) ? !stops[0] : !(stops[0] && stops[1]);
                    req_seq[i]  = req_seq[i] + 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        rxd0 = 1'b1;
        rxd1 = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic consume(input int i);
        @(negedge clk);
        if (i == 0) ready0 = 1'b1; else ready1 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        ready1 = 1'b0;
        chk($sformatf("consume_valid%0d", i), 32'((i == 0) ? valid0 : valid1), 32'd0);
    endtask

    initial begin
        ce = 1'b1; clr_n = 1'b0; rxd0 = 1'b1; rxd1 = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (valid0 && !pv0) rise0 = cyc;
                pv0 = valid0;
                if (ovr0) novr0++;
                if (clr_n) begin
                    cmp_one(0, valid0, data0, perr0, ferr0, ovr0);
                    cmp_one(1, valid1, data1, perr1, ferr1, ovr1);
                end
            end
            begin
                repeat (3) @(negedge clk);
                chk("rst_valid0", 32'(valid0), 0);
                chk("rst_data0", 32'(data0), 0);
                chk("rst_flags0", {29'd0, perr0, ferr0, ovr0}, 0);
                chk("rst_status0", 32'(status0), 0);
                chk("rst_valid1", 32'(valid1), 0);
                chk("rst_status1", 32'(status1), 0);
                clr_n = 1'b1;
                idle(10);

                send(0, 8'hA5, 1'b0, 2'b11, -1, k);
                chk("a5_latency", 32'(rise0 - k), 32'd157);
                chk("a5_valid", 32'(valid0), 1);
                chk("a5_data", 32'(data0), 32'hA5);
                chk("a5_errs", {30'd0, perr0, ferr0}, 0);
                idle(5);
                chk("a5_hold_valid", 32'(valid0), 1);
                chk("a5_hold_data", 32'(data0), 32'hA5);
                consume(0);

                @(negedge clk);
                rxd0 = 1'b0;
                k = cyc;
                for (int t = 1; t <= 13; t++) begin
                    @(negedge clk);
                    if (t == 4) rxd0 = 1'b1;
                    if (t == 2) chk("fs_status_idle", 32'(status0), 0);
                    if (t == 3) chk("fs_status_start", 32'(status0), 1);
                    if (t == 12) chk("fs_status_pre", 32'(status0), 1);
                    if (t == 13) chk("fs_status_back", 32'(status0), 0);
                end
                idle(10);
                chk("fs_no_valid", 32'(valid0), 0);
                send(0, 8'h3C, 1'b0, 2'b11, -1, k);
                chk("3c_data", 32'(data0), 32'h3C);
                consume(0);

                send(0, 8'h55, 1'b0, 2'b10, -1, k);
                idle(20);
                chk("55_data", 32'(data0), 32'h55);
                chk("55_frame_err", 32'(ferr0), 1);
                consume(0);

                n0 = novr0;
                send(0, 8'h11, 1'b0, 2'b11, -1, k);
                send(0, 8'h22, 1'b0, 2'b11, -1, k);
                chk("ovr_keep_data", 32'(data0), 32'h11);
                chk("ovr_pulses", 32'(novr0 - n0), 1);
                fork
                    send(0, 8'h22, 1'b0, 2'b11, -1, k);
                    begin
                        repeat (157) @(negedge clk);
                        ready0 = 1'b1;
                        @(negedge clk);
                        ready0 = 1'b0;
                    end
                join
                chk("swap_data", 32'(data0), 32'h22);
                chk("swap_valid", 32'(valid0), 1);
                chk("swap_no_ovr", 32'(novr0 - n0), 1);
                consume(0);

                send(0, 8'h02, 1'b0, 2'b11, 1, k);
                chk("glitch_data", 32'(data0), 32'h02);
                chk("glitch_valid", 32'(valid0), 1);

                rxd0 = 1'b0;
                repeat (16) @(negedge clk);
                rxd0 = 1'b1;
                repeat (20) @(negedge clk);
                chk("mid_status_data", 32'(status0), 2);
                clr_n = 1'b0;
                #1;
                chk("mid_rst_valid", 32'(valid0), 0);
                chk("mid_rst_data", 32'(data0), 0);
                chk("mid_rst_flags", {29'd0, perr0, ferr0, ovr0}, 0);
                chk("mid_rst_status", 32'(status0), 0);
                repeat (3) @(negedge clk);
                clr_n = 1'b1;
                idle(10);
                chk("post_rst_valid", 32'(valid0), 0);

                send(1, 8'h07, 1'b1, 2'b11, -1, k);
                chk("par0_data", 32'(data1), 32'h07);
                chk("par0_perr", 32'(perr1), 1);
                chk("par0_ferr", 32'(ferr1), 0);
                consume(1);
                send(1, 8'h07, 1'b0, 2'b11, -1, k);
                chk("par1_perr", 32'(perr1), 0);
                consume(1);
                send(1, 8'hC3, 1'b0, 2'b01, -1, k);
                idle(20);
                chk("stop2_data", 32'(data1), 32'hC3);
                chk("stop2_ferr", 32'(ferr1), 1);
                chk("stop2_perr", 32'(perr1), 0);
                consume(1);
                idle(5);
            end
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver: oversampled start detection, majority-vote bit sampling, configurable data width, parity and stop bits, and a valid/ready output handshake with per-word error flags. It is the next-generation receive path of the synth's MIDI/serial input. It replaces the fixed 8N1 receive state machine plus external counters with one self-contained block. It sits between the `rxd` pin and the byte consumer (MIDI parser), fed by a shared oversample tick from the baud generator.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `OVERSAMPLE`, default 16: `ce` ticks per bit period; even, at least 8.
- `PARITY`, default 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `clk` in 1: system clock.
- `clr_n` in 1: reset, asynchronous, active-low.
- `ce` in 1: oversample tick, one-cycle pulse, OVERSAMPLE per bit.
- `rxd` in 1: serial input, asynchronous to `clk`, idle high.
- `data` out DATA_BITS: received word, LSB = first bit on the wire.
- `valid` out 1: `data` and its flags hold an unconsumed word.
- `ready` in 1: consumer accepts the word when `valid && ready`.
- `parity_err` out 1: parity mismatch on the word in `data`. Always 0 when PARITY=0.
- `frame_err` out 1: at least one stop bit sampled as 0 on the word in `data`.
- `overrun` out 1: one-cycle pulse; a completed word was dropped.
- `status` out 3: FSM state. 000 IDLE, 001 START, 010 DATA, 011 PARITY, 100 STOP.

## Operation
- `rxd` passes through a 2-FF synchroniser clocked every `clk`; both flops reset to 1. Everything else advances only on cycles with `ce`=1.
- Tick counter `cnt` has width clog2(OVERSAMPLE) and runs 0..OVERSAMPLE-1 within each bit. Let H = OVERSAMPLE/2.
- Samples are taken at `cnt` = H-1, H and H+1. The bit value is the majority of the three, decided at `cnt` = H+1.
- IDLE: on the first tick with synced `rxd`=0, go to START with `cnt`=0.
- START: at the decision point, a majority of 1 means a false start: return to IDLE and produce no output. Otherwise, at `cnt`=OVERSAMPLE-1, go to DATA with `cnt`=0 and bit index 0.
- DATA: each decided bit shifts in LSB-first. At `cnt`=OVERSAMPLE-1 of bit DATA_BITS-1, go to PARITY if PARITY≠0, else to STOP.
- PARITY: the decided bit is checked against the XOR of the data bits. Even mode expects XOR; odd mode expects ~XOR. Go to STOP at end of bit.
- STOP: each stop bit is decided; any 0 sets the frame error. On the decision point of the last stop bit (`cnt`=H+1), the word completes and the FSM returns to IDLE immediately, so the next start edge is not missed. Between stop bits of a 2-stop frame, transition at `cnt`=OVERSAMPLE-1.
- Completion:
  - If `valid`=0, or `valid && ready` in the same cycle: load `data`, `parity_err` and `frame_err`, and set `valid`=1.
  - Otherwise: the new word is discarded, the held word and flags are unchanged, and `overrun` pulses for 1 cycle.
- `valid` clears on `valid && ready` when no completion occurs in that cycle.
- Words with errors are still delivered. A break (all zeros, frame error) appears as `data`=0 with `frame_err`=1.

## Timing
- Reset values: `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `status`=000. Internal counters are 0 and the synchroniser is 11.
- `clr_n` low mid-frame aborts the frame at once. No word is produced and any held word is lost.
- Latency: `valid` rises 1 `clk` after the `ce` cycle holding the last stop decision. That cycle is the (H+1)-th tick of the last stop bit, plus 2 `clk` of synchroniser delay relative to the line.
- Handshake: `valid` stays high with stable `data` and flags until accepted. `ready` is ignored while `valid`=0. A combinational path from `ready` to outputs is not allowed; all outputs are registered.
- A `ce`=0 cycle freezes the FSM and counters, but not the synchroniser.
- `status` reflects the registered state.

## Test plan
- 8N1, OVERSAMPLE=16, `ce` every cycle, send 0xA5 with `ready`=0 → `valid`=1, `data`=0xA5, errors 0. `valid` is held until `ready` pulses, then clears next cycle.
- False start: `rxd` low for 4 ticks then high → `status` returns to 000 at tick H+1, no `valid`, and a following 0x3C is received correctly.
- PARITY=1, send 0x07 with parity bit 0 → `data`=0x07, `parity_err`=1. Repeat with parity bit 1 → `parity_err`=0.
- Stop bit driven 0 for 0x55 → `data`=0x55, `frame_err`=1. With STOP_BITS=2, a bad second stop bit alone also sets `frame_err`.
- Back-to-back 0x11 then 0x22 with `ready`=0 → `data` stays 0x11 and a 1-cycle `overrun` pulse occurs. Repeat with `ready`=1 on the completion cycle → `data`=0x22, no `overrun`.
- Majority filter: a single-tick low glitch at `cnt`=H inside a 1 data bit → bit read as 1. Then assert `clr_n`=0 mid-DATA → outputs at reset values, `status`=000.
